ysyx_22040895_immctl: RTL and testbench

// - Immediate-generation sequencer in the IDU: accepts one 32-bit RV64 instruction on a valid/ready handshake.
// - Decodes its format, slices and drives the 12-bit/20-bit fields and select into ysyx_22040895_sext.
// - Captures the sign-extended result and applies the format shift (B/J <<1, U <<12).
// - Presents the final 64-bit immediate downstream on a valid/ready handshake.

---
 rtl/ysyx_22040895_immctl.sv | 131 +++++++++++++
 tb/tb_ysyx_22040895_immctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_immctl.sv
// Immediate-generation sequencer: decodes one RV64 instruction, feeds the sign extender,
// applies the format shift and hands the 64-bit immediate downstream.
module ysyx_22040895_immctl #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [ILEN-1:0] in_inst_i,
  output logic            immsel_o,
  output logic [11:0]     imm1_o,
  output logic [19:0]     imm2_o,
  input  logic [XLEN-1:0] simm_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_fmt_o
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXT, HOLD} state_t;

  typedef struct packed {
    logic        sel;
    logic [11:0] imm1;
    logic [19:0] imm2;
    logic [2:0]  fmt;
  } dec_t;

  state_t          state;
  logic [2:0]      fmt_q;
  dec_t            dec;
  logic [XLEN-1:0] fixed;
  logic            accept;

  assign in_ready_o = !flush_i && ((state == IDLE) || (state == HOLD && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    dec     = '0;
    dec.fmt = FMT_ILL;
    case (in_inst_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b1110011: begin
        dec.fmt  = FMT_I;
        dec.sel  = 1'b1;
        dec.imm1 = in_inst_i[31:20];
      end
      7'b0100011: begin
        dec.fmt  = FMT_S;
        dec.sel  = 1'b1;
        dec.imm1 = {in_inst_i[31:25], in_inst_i[11:7]};
      end
      7'b1100011: begin
        dec.fmt  = FMT_B;
        dec.sel  = 1'b1;
        dec.imm1 = {in_inst_i[31], in_inst_i[7], in_inst_i[30:25], in_inst_i[11:8]};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt  = FMT_U;
        dec.imm2 = in_inst_i[31:12];
      end
      7'b1101111: begin
        dec.fmt  = FMT_J;
        dec.imm2 = {in_inst_i[31], in_inst_i[19:12], in_inst_i[20], in_inst_i[30:21]};
      end
      7'b0110011, 7'b0111011: dec.fmt = FMT_R;
      default: ;
    endcase
  end

  // B/J fields drop the implicit zero LSB and U drops the low 12 bits; restore them here.
  always_comb begin
    fixed = '0;
    case (fmt_q)
      FMT_I, FMT_S: fixed = simm_i;
      FMT_B, FMT_J: fixed = simm_i << 1;
      FMT_U:        fixed = simm_i << 12;
      default:      fixed = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fmt_q       <= FMT_R;
      immsel_o    <= 1'b0;
      imm1_o      <= '0;
      imm2_o      <= '0;
      out_valid_o <= 1'b0;
      out_imm_o   <= '0;
      out_fmt_o   <= FMT_R;
    end else if (flush_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
    end else if (accept) begin
      // covers both IDLE and the HOLD case where the downstream handshake completes
      state       <= EXT;
      fmt_q       <= dec.fmt;
      immsel_o    <= dec.sel;
      imm1_o      <= dec.imm1;
      imm2_o      <= dec.imm2;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        EXT: begin
          out_imm_o   <= fixed;
          out_fmt_o   <= fmt_q;
          out_valid_o <= 1'b1;
          state       <= HOLD;
        end
        HOLD: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_immctl.sv
// Scoreboard bench for the immediate sequencer; a behavioural sign extender closes the sext loop.
module tb_ysyx_22040895_immctl;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid_i, in_ready_o, out_ready_i;
  logic [31:0] in_inst_i;
  logic        immsel_o, out_valid_o;
  logic [11:0] imm1_o;
  logic [19:0] imm2_o;
  logic [63:0] simm_i, out_imm_o;
  logic [2:0]  out_fmt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;
  exp_t sb[$];

  ysyx_22040895_immctl #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_inst_i(in_inst_i),
    .immsel_o(immsel_o), .imm1_o(imm1_o), .imm2_o(imm2_o), .simm_i(simm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_imm_o(out_imm_o), .out_fmt_o(out_fmt_o)
  );

  always #5 clk = ~clk;

  assign simm_i = immsel_o ? {{52{imm1_o[11]}}, imm1_o} : {{44{imm2_o[19]}}, imm2_o};

  // Architectural immediate straight from the ISA encoding.
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e.imm = '0;
    e.fmt = 3'd7;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b1110011: begin
        e.imm = {{52{i[31]}}, i[31:20]}; e.fmt = 3'd1;
      end
      7'b0100011: begin e.imm = {{52{i[31]}}, i[31:25], i[11:7]}; e.fmt = 3'd2; end
      7'b1100011: begin
        e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; e.fmt = 3'd3;
      end
      7'b0110111, 7'b0010111: begin e.imm = {{32{i[31]}}, i[31:12], 12'b0}; e.fmt = 3'd4; end
      7'b1101111: begin
        e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; e.fmt = 3'd5;
      end
      7'b0110011, 7'b0111011: e.fmt = 3'd0;
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready held high; instruction bus is scrambled after accept.
  task automatic run_txn(input logic [31:0] inst);
    exp_t e;
    logic exp_sel;
    e = model(inst);
    exp_sel = (e.fmt == 3'd1) || (e.fmt == 3'd2) || (e.fmt == 3'd3);
    in_valid_i = 1'b1;
    in_inst_i  = inst;
    sb.push_back(e);
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL txn_ready inst=%h got=%b exp=1", inst, in_ready_o); end
    tick;
    in_valid_i = 1'b0;
    in_inst_i  = $urandom;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL txn_early_valid inst=%h got=%b exp=0", inst, out_valid_o); end
    if (e.fmt inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) begin
      checks++;
      if (immsel_o !== exp_sel) begin failures++; $display("FAIL txn_immsel inst=%h got=%b exp=%b", inst, immsel_o, exp_sel); end
    end
    tick;
    checks++;
    if (out_valid_o !== 1'b1) begin failures++; $display("FAIL txn_valid inst=%h got=%b exp=1", inst, out_valid_o); end
    e = sb.pop_front();
    checks++;
    if (out_imm_o !== e.imm) begin failures++; $display("FAIL txn_imm inst=%h got=%h exp=%h", inst, out_imm_o, e.imm); end
    checks++;
    if (out_fmt_o !== e.fmt) begin failures++; $display("FAIL txn_fmt inst=%h got=%0d exp=%0d", inst, out_fmt_o, e.fmt); end
    tick;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL txn_drop inst=%h got=%b exp=0", inst, out_valid_o); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; out_ready_i = 1'b1;
    tick; tick;
    checks++;
    if ({out_valid_o, out_imm_o, out_fmt_o, immsel_o, imm1_o, imm2_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b imm=%h fmt=%0d sel=%b i1=%h i2=%h exp=all0",
               out_valid_o, out_imm_o, out_fmt_o, immsel_o, imm1_o, imm2_o);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_formats;
    logic [31:0] insts [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800000B7,
                               32'h0010006F, 32'h002081B3, 32'hFFFFFFFF};
    logic [63:0] imms  [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'hFFFFFFFF80000000, 64'h800, 64'h0, 64'h0};
    logic [2:0]  fmts  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
    for (int k = 0; k < 7; k++) begin
      run_txn(insts[k]);
      checks++;
      if (out_imm_o !== imms[k] || out_fmt_o !== fmts[k]) begin
        failures++;
        $display("FAIL fmt_const k=%0d got=%h/%0d exp=%h/%0d", k, out_imm_o, out_fmt_o, imms[k], fmts[k]);
      end
      if (k == 1) begin
        checks++;
        if (immsel_o !== 1'b1 || imm1_o !== 12'hFFC) begin failures++; $display("FAIL sw_fields got sel=%b imm1=%h exp sel=1 imm1=ffc", immsel_o, imm1_o); end
      end
      if (k == 3) begin
        checks++;
        if (immsel_o !== 1'b0 || imm2_o !== 20'h80000) begin failures++; $display("FAIL lui_fields got sel=%b imm2=%h exp sel=0 imm2=80000", immsel_o, imm2_o); end
      end
      if (k == 6) begin
        checks++;
        if (imm1_o !== 12'h0 || imm2_o !== 20'h0) begin failures++; $display("FAIL ill_fields got imm1=%h imm2=%h exp=0", imm1_o, imm2_o); end
      end
    end
  endtask

  task automatic test_random;
    logic [6:0] ops [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b0111011, 7'b0001111};
    for (int k = 0; k < 20; k++) begin
      logic [31:0] r;
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      run_txn(r);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_inst_i   = 32'h0010006F;
    sb.push_back(model(32'h0010006F));
    tick;
    in_inst_i = 32'hFFF00093;
    tick;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_imm_o !== 64'h800 || out_fmt_o !== 3'd5) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%b imm=%h fmt=%0d exp v=1 imm=800 fmt=5", k, out_valid_o, out_imm_o, out_fmt_o);
      end
      checks++;
      if (in_ready_o !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", k, in_ready_o); end
      tick;
    end
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready_o); end
    e = sb.pop_front();
    checks++;
    if (out_imm_o !== e.imm) begin failures++; $display("FAIL b2b_first got=%h exp=%h", out_imm_o, e.imm); end
    sb.push_back(model(32'hFFF00093));
    tick;
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", out_valid_o); end
    tick;
    e = sb.pop_front();
    checks++;
    if (out_valid_o !== 1'b1 || out_imm_o !== e.imm || out_imm_o !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL b2b_second got v=%b imm=%h exp v=1 imm=%h", out_valid_o, out_imm_o, e.imm);
    end
    tick;
  endtask

  task automatic test_flush;
    in_valid_i = 1'b1;
    in_inst_i  = 32'hFFF00093;
    tick;
    flush_i = 1'b1;
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready_o); end
    tick;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid_o, in_ready_o);
    end
    checks++;
    if (imm1_o !== 12'hFFF) begin failures++; $display("FAIL flush_fields got=%h exp=fff", imm1_o); end
    tick;
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_novalid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_reset_mid;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_inst_i   = 32'hFE112E23;
    tick;
    in_valid_i = 1'b0;
    tick;
    checks++;
    if (out_valid_o !== 1'b1) begin failures++; $display("FAIL rstmid_hold got=%b exp=1", out_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_imm_o, out_fmt_o, immsel_o, imm1_o, imm2_o} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b imm=%h fmt=%0d sel=%b i1=%h i2=%h exp=all0",
               out_valid_o, out_imm_o, out_fmt_o, immsel_o, imm1_o, imm2_o);
    end
    tick;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    tick;
    run_txn(32'hFE000CE3);
  endtask

  initial begin
    test_reset;
    test_formats;
    test_random;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
